// File: rtl/controle_tampagem.sv
// rtl/controle_tampagem.sv - capping station sequencer: capping pulse, cork magazine refill and empty alarm.
// Optional bottle counter port garrafas[7:0] when CONTROLE_CONTAGEM_EN is defined.
module controle_tampagem #(
    parameter int CAP_MAX    = 20,
    parameter int REFILL_AT  = 5,
    parameter int REFILL_QTY = 15,
    parameter int DISP_INIT  = 3,
    parameter int PULSE_LEN  = 4
) (
    input  logic       CLKplaca,
    input  logic       iniN,
    input  logic       garrafa,
    input  logic       adicionar,
    input  logic       repor,
    output logic       Tampar,
    output logic [4:0] rolhas,
    output logic [1:0] lote,
    output logic       TemR,
    output logic       alarme,
    output logic       ocupado
`ifdef CONTROLE_CONTAGEM_EN
    ,
    output logic [7:0] garrafas
`endif
);

    localparam logic [4:0] CAP5       = 5'(CAP_MAX);
    localparam logic [5:0] CAP6       = 6'(CAP_MAX);
    localparam logic [4:0] LIMIAR     = 5'(REFILL_AT);
    localparam logic [4:0] QTY5       = 5'(REFILL_QTY);
    localparam logic [5:0] QTY6       = 6'(REFILL_QTY);
    localparam logic [1:0] DISP2      = 2'(DISP_INIT);
    localparam logic [7:0] PULSO_INIT = 8'(PULSE_LEN - 1);

    typedef enum logic [2:0] {IDLE, TAMPAR, ESPERA, RECARGA, VAZIO} estado_t;

    estado_t    estado;
    logic       manual;
    logic [7:0] pulso;
    logic       pend;
    logic       lote_ok;
    logic [5:0] soma;

    assign pend    = ((rolhas <= LIMIAR) || manual) && (lote != 2'd0);
    // a simultaneous repor refills the dispenser before adicionar is judged
    assign lote_ok = repor ? (DISP2 != 2'd0) : (lote != 2'd0);
    assign soma    = {1'b0, rolhas} + QTY6;
    assign TemR    = (rolhas != 5'd0);
    assign ocupado = (estado != IDLE);

    always_ff @(posedge CLKplaca or negedge iniN) begin
        if (!iniN) begin
            estado   <= IDLE;
            rolhas   <= QTY5;
            lote     <= DISP2;
            Tampar   <= 1'b0;
            alarme   <= 1'b0;
            manual   <= 1'b0;
            pulso    <= 8'd0;
`ifdef CONTROLE_CONTAGEM_EN
            garrafas <= 8'd0;
`endif
        end else begin
            case (estado)
                IDLE: begin
                    if (pend) begin
                        estado <= RECARGA;
                    end else if (garrafa && rolhas != 5'd0) begin
                        estado   <= TAMPAR;
                        rolhas   <= rolhas - 5'd1;
                        Tampar   <= 1'b1;
                        pulso    <= PULSO_INIT;
`ifdef CONTROLE_CONTAGEM_EN
                        garrafas <= garrafas + 8'd1;
`endif
                    end else if (garrafa && lote == 2'd0) begin
                        estado <= VAZIO;
                        alarme <= 1'b1;
                    end
                end
                TAMPAR: begin
                    if (pulso == 8'd0) begin
                        Tampar <= 1'b0;
                        estado <= ESPERA;
                    end else begin
                        pulso <= pulso - 8'd1;
                    end
                end
                ESPERA: begin
                    if (!garrafa) estado <= IDLE;
                end
                RECARGA: begin
                    rolhas <= (soma > CAP6) ? CAP5 : soma[4:0];
                    if (lote != 2'd0) lote <= lote - 2'd1;
                    manual <= 1'b0;
                    estado <= IDLE;
                end
                VAZIO: begin
                    if (repor) begin
                        estado <= IDLE;
                        alarme <= 1'b0;
                    end
                end
                default: estado <= IDLE;
            endcase
            if (adicionar && lote_ok) manual <= 1'b1;
            if (repor) lote <= DISP2;
        end
    end

endmodule
